// File: rtl/busca_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, JumpValue
// encodings, IR field positions and the HALT instruction word.
package busca_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] JV_INC = 2'b00;
    localparam logic [1:0] JV_REL = 2'b01;
    localparam logic [1:0] JV_ABS = 2'b10;
    localparam logic [1:0] JV_REG = 2'b11;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 6;
    localparam int FUN_MSB = 2;
    localparam int FUN_LSB = 0;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    localparam logic [7:0] HALT_INSTR = 8'hC7;

endpackage

// File: rtl/calc_prox_pc.sv
// Combinational next-PC selection from the control unit's Jump/Cond/JumpValue.
// All arithmetic wraps modulo 2^PC_W.
module calc_prox_pc
    import busca_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0]  i_pc,
    input  logic [IMM_W-1:0] i_imm,
    input  logic [7:0]       i_jump_reg,
    input  logic             i_jump,
    input  logic             i_cond,
    input  logic             i_zero,
    input  logic [1:0]       i_jump_value,
    output logic [PC_W-1:0]  o_next_pc
);

    logic [PC_W-1:0] w_inc;
    logic [PC_W-1:0] w_imm_sext;
    logic [PC_W-1:0] w_imm_zext;
    logic            w_taken;

    assign w_inc      = i_pc + PC_W'(1);
    assign w_imm_sext = {{(PC_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
    assign w_imm_zext = {{(PC_W-IMM_W){1'b0}}, i_imm};
    assign w_taken    = i_jump | (i_cond & i_zero);

    always_comb begin
        o_next_pc = w_inc;
        if (w_taken) begin
            unique case (i_jump_value)
                JV_INC:  o_next_pc = w_inc;
                JV_REL:  o_next_pc = i_pc + w_imm_sext;
                JV_ABS:  o_next_pc = w_imm_zext;
                default: o_next_pc = PC_W'(i_jump_reg);
            endcase
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: PC, req/ack fetch FSM and IR field split.
// Optional halt support is enabled by defining BUSCA_HALT_EN.
module busca_instrucao
    import busca_pkg::*;
#(
    parameter int            PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    input  logic            stall,
    input  logic            pc_write,
    input  logic            jump,
    input  logic            cond,
    input  logic            zero,
    input  logic [1:0]      jump_value,
    input  logic [7:0]      jump_reg,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      instr,
    output logic [1:0]      opcode,
    output logic [2:0]      funct,
    output logic [5:0]      imm,
    output logic            instr_valid,
    output logic            halted
);

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [PC_W-1:0] w_next_pc;
    logic            w_ir_load;
    logic            w_pc_load;

    assign w_ir_load = (r_state == ST_FETCH) && imem_ack;
    // Stall has priority over PCWrite so a held instruction never retires.
    assign w_pc_load = (r_state == ST_ISSUE) && !stall && pc_write;

    calc_prox_pc #(.PC_W(PC_W)) u_calc_prox_pc (
        .i_pc         (r_pc),
        .i_imm        (r_ir[IMM_MSB:IMM_LSB]),
        .i_jump_reg   (jump_reg),
        .i_jump       (jump),
        .i_cond       (cond),
        .i_zero       (zero),
        .i_jump_value (jump_value),
        .o_next_pc    (w_next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_START;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_ir_load) r_ir <= imem_data;
            if (w_pc_load) r_pc <= w_next_pc;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_START: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
`ifdef BUSCA_HALT_EN
                    w_state_nxt = (imem_data == HALT_INSTR) ? ST_HALTED : ST_ISSUE;
`else
                    w_state_nxt = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: if (w_pc_load) w_state_nxt = ST_FETCH;
`ifdef BUSCA_HALT_EN
            ST_HALTED: w_state_nxt = ST_HALTED;
`endif
            default: w_state_nxt = ST_START;
        endcase
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign instr_valid = (r_state == ST_ISSUE);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_ir;
    assign opcode      = r_ir[OPC_MSB:OPC_LSB];
    assign funct       = r_ir[FUN_MSB:FUN_LSB];
    assign imm         = r_ir[IMM_MSB:IMM_LSB];

`ifdef BUSCA_HALT_EN
    assign halted = (r_state == ST_HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: directed plan vectors plus
// randomized fetch/issue sequences against an arithmetic next-PC model.
module tb_busca_instrucao;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       stall, pc_write, jump, cond, zero;
    logic [1:0] jump_value;
    logic [7:0] jump_reg;
    logic [7:0] pc, instr;
    logic [1:0] opcode;
    logic [2:0] funct;
    logic [5:0] imm;
    logic       instr_valid, halted;

    int checks = 0;
    int errors = 0;
    int m_pc;

    busca_instrucao #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .stall(stall),
        .pc_write(pc_write), .jump(jump), .cond(cond), .zero(zero),
        .jump_value(jump_value), .jump_reg(jump_reg), .pc(pc), .instr(instr),
        .opcode(opcode), .funct(funct), .imm(imm), .instr_valid(instr_valid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Reference next-PC from the branch rules, using plain integer arithmetic.
    function automatic int ref_next(int cur, int im, int jr, bit j, bit c, bit z, int jv);
        int simm;
        if (!(j || (c && z))) return (cur + 1) % 256;
        simm = (im >= 32) ? im - 64 : im;
        case (jv)
            0:       return (cur + 1) % 256;
            1:       return ((cur + simm) % 256 + 256) % 256;
            2:       return im;
            default: return jr;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [7:0] d);
        imem_ack = 1'b1; imem_data = d;
        tick();
        imem_ack = 1'b0; imem_data = $urandom;
    endtask

    task automatic retire(input bit j, input bit c, input bit z, input logic [1:0] jv,
                          input logic [7:0] jr);
        m_pc = ref_next(m_pc, int'(instr[5:0]), int'(jr), j, c, z, int'(jv));
        jump = j; cond = c; zero = z; jump_value = jv; jump_reg = jr;
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0; jump = 1'b0; cond = 1'b0; zero = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; imem_data = 8'h00; stall = 1'b0;
        pc_write = 1'b0; jump = 1'b0; cond = 1'b0; zero = 1'b0;
        jump_value = 2'b00; jump_reg = 8'h00;
        repeat (3) tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (instr !== 8'h00) begin errors++; $display("FAIL reset_ir got %h exp 00", instr); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL release_req_early got %b exp 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=00", imem_req, imem_addr);
        end
        m_pc = 0;
    endtask

    task automatic test_seq_fetch();
        fetch(8'h45);
        checks++; if (instr_valid !== 1'b1 || instr !== 8'h45) begin
            errors++; $display("FAIL seq_capture got valid=%b ir=%h exp 1/45", instr_valid, instr);
        end
        checks++; if (opcode !== 2'b01 || funct !== 3'b101 || imm !== 6'b000101) begin
            errors++; $display("FAIL seq_fields got %b/%b/%b exp 01/101/000101", opcode, funct, imm);
        end
        retire(1'b0, 1'b0, 1'b0, 2'b11, 8'h77);
        checks++; if (imem_addr !== 8'h01 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL seq_next got addr=%h req=%b valid=%b exp 01/1/0", imem_addr, imem_req, instr_valid);
        end
    endtask

    task automatic test_branches();
        fetch(8'h00); retire(1'b1, 1'b0, 1'b0, 2'b11, 8'h10);
        checks++; if (pc !== 8'h10) begin errors++; $display("FAIL ind_to_10 got %h exp 10", pc); end
        fetch(8'h3C); retire(1'b0, 1'b1, 1'b1, 2'b01, 8'h00);
        checks++; if (pc !== 8'h0C) begin errors++; $display("FAIL rel_taken got %h exp 0C", pc); end
        fetch(8'h00); retire(1'b1, 1'b0, 1'b0, 2'b11, 8'h10);
        fetch(8'h3C); retire(1'b0, 1'b1, 1'b0, 2'b01, 8'h00);
        checks++; if (pc !== 8'h11) begin errors++; $display("FAIL rel_not_taken got %h exp 11", pc); end
        fetch(8'h00); retire(1'b1, 1'b0, 1'b0, 2'b11, 8'hFF);
        fetch(8'h3F); retire(1'b0, 1'b0, 1'b1, 2'b10, 8'h55);
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap got %h exp 00", pc); end
        fetch(8'h00); retire(1'b1, 1'b0, 1'b0, 2'b11, 8'h80);
        checks++; if (pc !== 8'h80) begin errors++; $display("FAIL indirect got %h exp 80", pc); end
        fetch(8'h3F); retire(1'b1, 1'b0, 1'b0, 2'b10, 8'h00);
        checks++; if (pc !== 8'h3F) begin errors++; $display("FAIL absolute got %h exp 3F", pc); end
        fetch(8'h00); retire(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
        checks++; if (pc !== 8'h40) begin errors++; $display("FAIL taken_inc got %h exp 40", pc); end
    endtask

    task automatic test_handshake_stall();
        logic [7:0] addr0;
        addr0 = imem_addr;
        pc_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== addr0 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL ack_wait%0d got req=%b addr=%h valid=%b exp 1/%h/0", k, imem_req, imem_addr, instr_valid, addr0);
            end
        end
        pc_write = 1'b0;
        fetch(8'h12);
        stall = 1'b1; pc_write = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (pc !== 8'(m_pc) || instr_valid !== 1'b1) begin
                errors++; $display("FAIL stall%0d got pc=%h valid=%b exp %h/1", k, pc, instr_valid, 8'(m_pc));
            end
        end
        stall = 1'b0;
        m_pc = (m_pc + 1) % 256;
        tick();
        pc_write = 1'b0;
        checks++; if (pc !== 8'(m_pc) || imem_req !== 1'b1) begin
            errors++; $display("FAIL stall_release got pc=%h req=%b exp %h/1", pc, imem_req, 8'(m_pc));
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [1:0] jv;
        logic [7:0] jr;
        bit j, c, z;
        for (int it = 0; it < 150; it++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 8'(m_pc) || instr_valid !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_fetch got req=%b addr=%h valid=%b exp 1/%h/0", it, imem_req, imem_addr, instr_valid, 8'(m_pc));
            end
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                pc_write = 1'($urandom); jump = 1'($urandom); jump_value = 2'($urandom);
                tick();
                checks++; if (imem_req !== 1'b1 || pc !== 8'(m_pc) || instr_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd%0d_wait got req=%b pc=%h valid=%b exp 1/%h/0", it, imem_req, pc, instr_valid, 8'(m_pc));
                end
            end
            pc_write = 1'b0; jump = 1'b0;
            d = 8'($urandom);
`ifdef BUSCA_HALT_EN
            if (d == 8'hC7) d = 8'hC6;
`endif
            fetch(d);
            checks++; if (instr_valid !== 1'b1 || instr !== d || opcode !== d[7:6] || funct !== d[2:0] || imm !== d[5:0]) begin
                errors++; $display("FAIL rnd%0d_capture got valid=%b ir=%h exp 1/%h", it, instr_valid, instr, d);
            end
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                stall = 1'($urandom); pc_write = stall ? 1'($urandom) : 1'b0;
                imem_ack = 1'($urandom); imem_data = 8'($urandom);
                tick();
                checks++; if (pc !== 8'(m_pc) || instr !== d || instr_valid !== 1'b1) begin
                    errors++; $display("FAIL rnd%0d_hold got pc=%h ir=%h valid=%b exp %h/%h/1", it, pc, instr, instr_valid, 8'(m_pc), d);
                end
            end
            stall = 1'b0; imem_ack = 1'b0;
            j = 1'($urandom); c = 1'($urandom); z = 1'($urandom);
            jv = 2'($urandom); jr = 8'($urandom);
            retire(j, c, z, jv, jr);
            checks++; if (pc !== 8'(m_pc) || imem_req !== 1'b1) begin
                errors++; $display("FAIL rnd%0d_nextpc got pc=%h req=%b exp %h/1 (j=%b c=%b z=%b jv=%b)", it, pc, imem_req, 8'(m_pc), j, c, z, jv);
            end
        end
    endtask

    task automatic test_async_reset();
        fetch(8'h9A);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 8'h00 || instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 8'h00) begin
            errors++; $display("FAIL async_reset got pc=%h valid=%b req=%b ir=%h exp 00/0/0/00", pc, instr_valid, imem_req, instr);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        m_pc = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL async_restart got req=%b addr=%h exp 1/00", imem_req, imem_addr);
        end
    endtask

    task automatic test_halt();
        fetch(8'hC7);
`ifdef BUSCA_HALT_EN
        pc_write = 1'b1; imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'(m_pc)) begin
                errors++; $display("FAIL halt%0d got halted=%b req=%b valid=%b pc=%h exp 1/0/0/%h", k, halted, imem_req, instr_valid, pc, 8'(m_pc));
            end
            tick();
        end
        pc_write = 1'b0; imem_ack = 1'b0;
`else
        checks++; if (halted !== 1'b0 || instr_valid !== 1'b1 || instr !== 8'hC7) begin
            errors++; $display("FAIL c7_issue got halted=%b valid=%b ir=%h exp 0/1/C7", halted, instr_valid, instr);
        end
        retire(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        checks++; if (pc !== 8'(m_pc) || imem_req !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL c7_retire got pc=%h req=%b halted=%b exp %h/1/0", pc, imem_req, halted, 8'(m_pc));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_branches();
        test_handshake_stall();
        test_random();
        test_async_reset();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch stage of the 8-bit processor, directly upstream of `UnidadeControle`. It holds the PC and fetches one 8-bit instruction per cycle pair over a req/ack handshake to instruction memory. It latches the instruction in an instruction register (IR) and splits it into the `Opcode`, `Funct` and immediate fields consumed by the control unit. The next PC is computed from the control unit's `PCWrite`, `Jump`, `Cond` and `JumpValue` outputs.

## Interface
- `PC_W`, 8, PC and memory address width
- `RESET_PC`, 8'h00, PC value after reset
- `clk`  in  1  clock, rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  PC_W  fetch address (= `pc`)
- `imem_ack`  in  1  data valid this cycle
- `imem_data`  in  8  instruction word
- `stall`  in  1  downstream hold; blocks PC update
- `pc_write`  in  1  `PCWrite` from the control unit
- `jump`  in  1  `Jump`
- `cond`  in  1  `Cond`
- `zero`  in  1  ALU zero flag
- `jump_value`  in  2  `JumpValue` target select
- `jump_reg`  in  8  register-file target for indirect jump
- `pc`  out  PC_W  current PC
- `instr`  out  8  IR contents
- `opcode`  out  2  `instr[7:6]`
- `funct`  out  3  `instr[2:0]`
- `imm`  out  6  `instr[5:0]`
- `instr_valid`  out  1  IR holds the instruction being executed
- `halted`  out  1  core halted (0 unless `BUSCA_HALT_EN`)

## Operation
- FSM states:
  - START: entered on reset; always goes to FETCH on the next edge.
  - FETCH: `imem_req`=1. On `imem_ack`: IR <= `imem_data`, go to ISSUE. Otherwise stay in FETCH.
  - ISSUE: `instr_valid`=1. If `stall`, stay. Else if `pc_write`: PC <= next_pc, go to FETCH. Else stay (multi-cycle instructions).
  - HALTED: only with `BUSCA_HALT_EN`; see Configuration.
- `imem_ack` is ignored outside FETCH. `pc_write` is ignored outside ISSUE.
- Branch taken when `jump | (cond & zero)`. If not taken, next_pc = pc+1 regardless of `jump_value`.
- `jump_value` encoding when taken:
  - 00: pc+1
  - 01: pc + sign-extended `imm` (relative to the current PC)
  - 10: zero-extended `imm`
  - 11: `jump_reg`
- All PC arithmetic is modulo 2^PC_W and wraps silently.
- `opcode`, `funct` and `imm` are driven from the IR at all times. They are meaningful only while `instr_valid`=1.

## Timing
- Reset values: `pc`=RESET_PC, IR=8'h00, `instr_valid`=0, `imem_req`=0, `halted`=0, state=START.
- `imem_req` and `instr_valid` are decoded from registered state, so there are no combinational paths from inputs to these outputs.
- First `imem_req` appears in the cycle after the first rising edge following reset release.
- `imem_addr` stays stable while `imem_req`=1. An ack in the same cycle as req is legal.
- Ack sampled at edge N: `instr_valid`=1 from N to N+1.
- `pc_write` with `stall`=0 sampled at edge M: new `pc` and `imem_req`=1 from M.
- Minimum of 2 cycles per instruction.
- `stall` and `pc_write` both high: stall wins, and the PC does not change.
- `rst_n` low in any state: all outputs return to reset values immediately, and any in-flight fetch is abandoned.

## Configuration
- `BUSCA_HALT_EN` defined:
  - IR value 8'hC7 (opcode 11, funct 111) is HALT.
  - On capture of HALT, go to HALTED instead of ISSUE.
  - In HALTED: `halted`=1, `instr_valid`=0, `imem_req`=0, PC frozen. Exit only by reset.
- `BUSCA_HALT_EN` not defined: 8'hC7 is issued like any other instruction, and `halted` is tied to 0.

## Structure
- Package `busca_pkg` holds:
  - state enum
  - `jump_value` encoding constants
  - IR field bit positions
  - HALT encoding constant
- Sub-module `calc_prox_pc`: combinational next-PC from pc, imm, jump_reg, jump, cond, zero, jump_value. It is instantiated once.

## Test plan
- Reset: hold `rst_n`=0 → `pc`=00, `imem_req`=0, `instr_valid`=0. Release → `imem_req`=1, `imem_addr`=00 one cycle later.
- Sequential fetch: ack with data 8'h45 → `opcode`=01, `funct`=101, `imm`=000101, `instr_valid`=1. Then `pc_write`=1, `jump`=0 → `imem_addr`=01.
- Relative branch at pc=10, `imm`=6'h3C, `cond`=1, `jump_value`=01:
  - `zero`=1 → next pc=0C
  - `zero`=0 → next pc=11
- Wrap and indirect:
  - pc=FF, not taken → 00
  - `jump`=1, `jump_value`=11, `jump_reg`=80 → 80
  - `jump_value`=10, `imm`=3F → 3F
- Handshake and stall:
  - Ack delayed 3 cycles → `imem_addr` held, `instr_valid`=0 throughout.
  - In ISSUE, `stall`=1 with `pc_write`=1 for 2 cycles → pc unchanged. Drop `stall` → pc updates.
- Halt and mid-op reset: with `BUSCA_HALT_EN`, fetch C7 → `halted`=1 and no further `imem_req`. Assert `rst_n`=0 while in ISSUE → state START, pc=RESET_PC, `instr_valid`=0 asynchronously.
